engine_read_write_index_generator: RTL and testbench
====================================================

ENGINE_READ_WRITE_INDEX_GENERATOR -- requirements
Module: engine_read_write_index_generator

Interface
REQ-001 SHALL have parameter ID_CU, default 0: compute-unit identifier, informational only.
REQ-002 SHALL have parameter ID_BUNDLE, default 0: bundle identifier, informational only.
REQ-003 SHALL have parameter ID_LANE, default 0: lane identifier, informational only.
REQ-004 SHALL have parameter ID_ENGINE, default 0: engine identifier, informational only.
REQ-005 SHALL have parameter INDEX_WIDTH, default 32: width of index, stride and end arithmetic.
REQ-006 SHALL have port ap_clk  in  1  sole clock; all state on the rising edge.
REQ-007 SHALL have port areset  in  1  reset, asynchronous and active-high.
REQ-008 SHALL have port configure_engine_in  in  CSRIndexConfiguration  configuration packet from the upstream configure stage.
REQ-009 SHALL have port configure_engine_rd_en  out  1  one-cycle pop request to the upstream configure FIFO.
REQ-010 SHALL have port request_out  out  MemoryPacket  generated index request.
REQ-011 SHALL have port request_out_ready  in  1  downstream can accept a request this cycle (not prog_full).
REQ-012 SHALL have port busy_out  out  1  high in any state other than IDLE.
REQ-013 SHALL have port done_out  out  1  one-cycle pulse when a configuration has been fully issued.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, WAIT, SETUP, BUSY, DONE.
REQ-015 IDLE SHALL go to REQ on the next cycle, unconditionally.
REQ-016 REQ SHALL assert configure_engine_rd_en for exactly one cycle, then go to WAIT.
REQ-017 WAIT SHALL capture configure_engine_in.payload and go to SETUP when configure_engine_in.valid=1.
REQ-018 WAIT SHALL return to REQ if no valid arrives within 4 cycles, covering a pop lost to an empty upstream FIFO.
REQ-019 configure_engine_in.valid in any state other than WAIT SHALL be dropped without a state change.
REQ-020 SETUP SHALL load index=index_start and step=(stride==0 ? 1 : stride).
REQ-021 SETUP SHALL go to DONE if index_start>=index_end, otherwise to BUSY.
REQ-022 In BUSY with request_out_ready=1, SHALL register request_out.valid=1 the next cycle, giving 1-cycle latency from ready to valid.
REQ-023 Each issued request SHALL carry: meta = captured meta; data.field[0]=index, field[1]=index_end, field[2]=array_pointer, field[3]=array_size.
REQ-024 After each issue, index SHALL advance by step.
REQ-025 The compare index+step>=index_end SHALL be evaluated in INDEX_WIDTH+1 bits so it never wraps; when true, that issue is the last one and the FSM goes to DONE.
REQ-026 In BUSY with request_out_ready=0, SHALL hold index and state and drive request_out.valid=0 the next cycle.
REQ-027 DONE SHALL pulse done_out for one cycle, then go to IDLE.
REQ-028 Request count SHALL equal ceil((index_end-index_start)/step), or 0 when index_start>=index_end.

Reset
REQ-029 areset asserted SHALL asynchronously force state=IDLE, index=0, captured configuration=0, request_out=0, configure_engine_rd_en=0, busy_out=0, done_out=0.
REQ-030 areset mid-operation SHALL discard the active configuration; no further requests are emitted for it after release.
REQ-031 First REQ after reset release SHALL occur 2 cycles after deassertion (IDLE->REQ).

Structure
REQ-032 State enum engine_read_write_index_generator_state SHALL live in PKG_ENGINE.
REQ-033 WAIT timeout constant (4) SHALL live in PKG_ENGINE.
REQ-034 CSRIndexConfiguration and MemoryPacket SHALL be reused unchanged from existing packages.
REQ-035 Block SHALL be single-level with no sub-module; counter and FSM are inline.

Verification
REQ-036 Verify: config start=0, end=4, stride=0, ready=1 -> 4 requests with field[0]=0,1,2,3 on consecutive cycles, then one done_out pulse.
REQ-037 Verify: start=3, end=10, stride=3 -> field[0]=3,6,9, then done.
REQ-038 Verify: start=5, end=5 -> zero requests; done_out pulses 2 cycles after valid was captured.
REQ-039 Verify: ready toggling 1,0,0,1 during a 4-index run -> valid follows ready delayed 1 cycle; no index skipped or duplicated.
REQ-040 Verify: no config available for 10 cycles -> rd_en re-pulses every 5 cycles (REQ+4 WAIT); first config then accepted normally.
REQ-041 Verify: start=0xFFFFFFFE, end=0xFFFFFFFF, stride=4, plus areset mid-BUSY on a separate run -> exactly one request with no wrap; areset forces all outputs 0 immediately.

Source files
------------

// File: rtl/engine_read_write_index_generator_pkg.sv
// Shared packet types and engine FSM definitions for the read/write index generator.
package PKG_MEMORY;

  typedef struct packed {
    logic [15:0] route;
    logic [15:0] opcode;
  } MemoryPacketMeta;

  typedef struct packed {
    logic [3:0][31:0] field;
  } MemoryPacketData;

  typedef struct packed {
    MemoryPacketMeta meta;
    MemoryPacketData data;
  } MemoryPacketPayload;

  typedef struct packed {
    logic               valid;
    MemoryPacketPayload payload;
  } MemoryPacket;

  typedef struct packed {
    logic [31:0] index_start;
    logic [31:0] index_end;
    logic [31:0] stride;
    logic [31:0] array_pointer;
    logic [31:0] array_size;
  } CSRIndexParam;

  typedef struct packed {
    MemoryPacketMeta meta;
    CSRIndexParam    param;
  } CSRIndexConfigurationPayload;

  typedef struct packed {
    logic                        valid;
    CSRIndexConfigurationPayload payload;
  } CSRIndexConfiguration;

endpackage

package PKG_ENGINE;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    SETUP = 3'd3,
    BUSY  = 3'd4,
    DONE  = 3'd5
  } engine_read_write_index_generator_state;

  // Cycles spent in WAIT before re-issuing the pop, in case it hit an empty FIFO.
  localparam int unsigned ENGINE_WAIT_TIMEOUT = 4;

endpackage

// File: rtl/engine_read_write_index_generator.sv
// Pops one index configuration, then walks index_start..index_end by stride,
// emitting one memory request per index while downstream is ready.
module engine_read_write_index_generator
  import PKG_MEMORY::*;
  import PKG_ENGINE::*;
#(
  parameter int ID_CU       = 0,
  parameter int ID_BUNDLE   = 0,
  parameter int ID_LANE     = 0,
  parameter int ID_ENGINE   = 0,
  parameter int INDEX_WIDTH = 32
) (
  input  logic                 ap_clk,
  input  logic                 areset,
  input  CSRIndexConfiguration configure_engine_in,
  output logic                 configure_engine_rd_en,
  output MemoryPacket          request_out,
  input  logic                 request_out_ready,
  output logic                 busy_out,
  output logic                 done_out
);

  if (INDEX_WIDTH < 1 || INDEX_WIDTH > 32 ||
      ID_CU < 0 || ID_BUNDLE < 0 || ID_LANE < 0 || ID_ENGINE < 0) begin : g_param_check
    $error("engine_read_write_index_generator: unsupported parameter values");
  end

  engine_read_write_index_generator_state state_q;
  CSRIndexConfigurationPayload            cfg_q;
  MemoryPacket                            request_q;
  logic [INDEX_WIDTH-1:0]                 index_q;
  logic [INDEX_WIDTH-1:0]                 step_q;
  logic [2:0]                             wait_cnt_q;
  logic                                   rd_en_q;
  logic                                   done_q;

  logic [INDEX_WIDTH-1:0] start_d;
  logic [INDEX_WIDTH-1:0] end_d;
  logic [INDEX_WIDTH-1:0] stride_d;
  logic [INDEX_WIDTH:0]   index_next_d;
  logic                   last_d;

  assign start_d  = INDEX_WIDTH'(cfg_q.param.index_start);
  assign end_d    = INDEX_WIDTH'(cfg_q.param.index_end);
  assign stride_d = INDEX_WIDTH'(cfg_q.param.stride);

  // One extra bit so an index near the top of the range cannot wrap past end.
  assign index_next_d = {1'b0, index_q} + {1'b0, step_q};
  assign last_d       = index_next_d >= {1'b0, end_d};

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      request_q  <= '0;
      index_q    <= '0;
      step_q     <= '0;
      wait_cnt_q <= '0;
      rd_en_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_en_q         <= 1'b0;
      done_q          <= 1'b0;
      request_q.valid <= 1'b0;
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          rd_en_q    <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (configure_engine_in.valid) begin
            cfg_q   <= configure_engine_in.payload;
            state_q <= SETUP;
          end else if (wait_cnt_q == 3'(ENGINE_WAIT_TIMEOUT - 1)) begin
            state_q <= REQ;
          end else begin
            wait_cnt_q <= wait_cnt_q + 3'd1;
          end
        end
        SETUP: begin
          index_q <= start_d;
          step_q  <= (stride_d == '0) ? INDEX_WIDTH'(1) : stride_d;
          state_q <= (start_d >= end_d) ? DONE : BUSY;
        end
        BUSY: begin
          if (request_out_ready) begin
            request_q.valid                 <= 1'b1;
            request_q.payload.meta          <= cfg_q.meta;
            request_q.payload.data.field[0] <= 32'(index_q);
            request_q.payload.data.field[1] <= cfg_q.param.index_end;
            request_q.payload.data.field[2] <= cfg_q.param.array_pointer;
            request_q.payload.data.field[3] <= cfg_q.param.array_size;
            index_q                         <= index_next_d[INDEX_WIDTH-1:0];
            if (last_d) state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign configure_engine_rd_en = rd_en_q;
  assign request_out            = request_q;
  assign busy_out               = (state_q != IDLE);
  assign done_out               = done_q;

endmodule

// File: tb/tb_engine_read_write_index_generator.sv
// Directed and randomized bench for the index generator against an arithmetic index-list model.
module tb_engine_read_write_index_generator;
  import PKG_MEMORY::*;

  logic                 ap_clk = 1'b0;
  logic                 areset = 1'b1;
  CSRIndexConfiguration cfg    = '0;
  logic                 rd_en;
  MemoryPacket          req;
  logic                 ready  = 1'b1;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;

  engine_read_write_index_generator dut (
    .ap_clk                 (ap_clk),
    .areset                 (areset),
    .configure_engine_in    (cfg),
    .configure_engine_rd_en (rd_en),
    .request_out            (req),
    .request_out_ready      (ready),
    .busy_out               (busy),
    .done_out               (done)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_request"}, req, 0);
  endtask

  function automatic logic pick_ready(input int mode, input int j);
    logic [3:0] pat;
    pat = 4'b1001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (j >= 1 && j <= 4) return pat[4-j];
    return 1'b1;
  endfunction

  // Waits for the next pop request; exp_gap < 0 skips the interval check.
  task automatic wait_rd_en(input int exp_gap);
    int  n;
    bit  found;
    n     = 0;
    found = 0;
    while (n < 50 && !found) begin
      @(negedge ap_clk);
      n++;
      chk("no_stray_request", req.valid, 0);
      chk("no_stray_done", done, 0);
      if (rd_en === 1'b1) found = 1;
    end
    chk("rd_en_seen", found, 1);
    if (exp_gap >= 0) chk("rd_en_gap", n, exp_gap);
  endtask

  // Called on the negedge where rd_en is visible; presents one configuration.
  task automatic run_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                         input int mode, input int abort_at, input bit inject);
    longint             q[$];
    longint             i;
    longint             v;
    longint             step;
    MemoryPacketMeta    meta;
    logic [31:0]        ptr;
    logic [31:0]        size;
    MemoryPacketPayload exp;
    logic               prev_ready;
    bit                 exp_valid;
    int                 done_at;
    bit                 finished;

    meta = MemoryPacketMeta'($urandom);
    ptr  = $urandom;
    size = $urandom;
    step = (st == 0) ? 64'sd1 : longint'({32'd0, st});
    for (i = longint'({32'd0, s}); i < longint'({32'd0, e}); i += step) q.push_back(i);

    cfg.valid                     = 1'b1;
    cfg.payload.meta              = meta;
    cfg.payload.param.index_start = s;
    cfg.payload.param.index_end   = e;
    cfg.payload.param.stride      = st;
    cfg.payload.param.array_pointer = ptr;
    cfg.payload.param.array_size  = size;

    @(negedge ap_clk);
    cfg.valid = 1'b0;
    chk("rd_en_one_shot", rd_en, 0);
    chk("busy_setup", busy, 1);
    chk("done_setup", done, 0);
    chk("valid_setup", req.valid, 0);
    ready      = pick_ready(mode, 0);
    prev_ready = ready;
    done_at    = (q.size() == 0) ? 2 : -1;
    finished   = 0;

    for (int j = 1; j < 300 && !finished; j++) begin
      @(negedge ap_clk);
      exp_valid = (j >= 2) && (q.size() > 0) && prev_ready;
      chk("req_valid", req.valid, exp_valid);
      if (exp_valid && req.valid === 1'b1) begin
        v                  = q.pop_front();
        exp.meta           = meta;
        exp.data.field[0]  = v[31:0];
        exp.data.field[1]  = e;
        exp.data.field[2]  = ptr;
        exp.data.field[3]  = size;
        chk("req_payload", req.payload, exp);
        if (q.size() == 0) done_at = j + 1;
      end
      chk("done_pulse", done, (j == done_at));
      chk("busy_level", busy, (j != done_at));
      if (j == done_at) begin
        finished = 1;
      end else if (j == abort_at) begin
        #1 areset = 1'b1;
        #1 chk_all_zero("async_reset");
        @(negedge ap_clk);
        areset   = 1'b0;
        finished = 1;
        q.delete();
      end else begin
        if (inject && j == 3) begin
          cfg.valid                     = 1'b1;
          cfg.payload.param.index_start = $urandom;
          cfg.payload.param.index_end   = $urandom;
        end
        if (j == 4) cfg.valid = 1'b0;
        ready      = pick_ready(mode, j);
        prev_ready = ready;
      end
    end
    chk("run_completed", finished, 1);
    cfg.valid = 1'b0;
    ready     = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge ap_clk);
    chk_all_zero("reset_hold");
    areset = 1'b0;

    wait_rd_en(2);
    run_cfg(32'd0, 32'd4, 32'd0, 0, -1, 0);

    wait_rd_en(2);
    run_cfg(32'd3, 32'd10, 32'd3, 0, -1, 0);

    wait_rd_en(2);
    run_cfg(32'd5, 32'd5, 32'd0, 0, -1, 0);

    wait_rd_en(2);
    run_cfg(32'd0, 32'd4, 32'd1, 2, -1, 0);

    wait_rd_en(2);
    wait_rd_en(5);
    wait_rd_en(5);
    run_cfg(32'd7, 32'd9, 32'd1, 0, -1, 0);

    wait_rd_en(2);
    run_cfg(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd4, 0, -1, 0);

    wait_rd_en(2);
    run_cfg(32'd0, 32'd20, 32'd1, 0, 5, 0);

    wait_rd_en(2);
    for (int r = 0; r < 8; r++) begin
      run_cfg(32'($urandom_range(0, 30)), 32'($urandom_range(0, 40)),
              32'($urandom_range(0, 5)), 1, -1, 1);
      wait_rd_en(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
